pwm_capture: RTL and testbench

//   Measures period and high time of CH independent PWM inputs, e.g. the 8-bit pwm bus

---
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 tb/tb_pwm_capture.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of CH asynchronous PWM inputs between
// consecutive rising edges, with per-channel timeout and a shared read mux.
module pwm_capture #(
  parameter int CH   = 8,
  parameter int CW   = 16,
  parameter int SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   pwm_in,
  input  logic [SELW-1:0] rd_sel,
  output logic [CW-1:0]   rd_period,
  output logic [CW-1:0]   rd_high,
  output logic            rd_valid,
  output logic            rd_stuck,
  output logic [CH-1:0]   new_meas
);

  typedef enum logic [0:0] {WAIT_RISE = 1'b0, MEAS = 1'b1} state_e;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [CH-1:0] meta_q, meta_d, sync_q, sync_d, lvl_q, lvl_d, prev_q, prev_d;
  logic [CH-1:0] rise;
  logic [CH-1:0] valid_q, valid_d, stuck_q, stuck_d, new_meas_q, new_meas_d;
  state_e        state_q   [CH];
  state_e        state_d   [CH];
  logic [CW-1:0] per_cnt_q [CH];
  logic [CW-1:0] per_cnt_d [CH];
  logic [CW-1:0] hi_cnt_q  [CH];
  logic [CW-1:0] hi_cnt_d  [CH];
  logic [CW-1:0] period_q  [CH];
  logic [CW-1:0] period_d  [CH];
  logic [CW-1:0] high_q    [CH];
  logic [CW-1:0] high_d    [CH];
  logic          sel_hit;

  // Synchronizer chain; the extra lvl stage places result updates after edge k+3.
  always_comb begin
    meta_d = pwm_in;
    sync_d = meta_q;
    lvl_d  = sync_q;
    prev_d = lvl_q;
    rise   = lvl_q & ~prev_q;
  end

  // State register for every flop in the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= {CH{1'b0}};
      sync_q     <= {CH{1'b0}};
      lvl_q      <= {CH{1'b0}};
      prev_q     <= {CH{1'b0}};
      valid_q    <= {CH{1'b0}};
      stuck_q    <= {CH{1'b0}};
      new_meas_q <= {CH{1'b0}};
      for (int i = 0; i < CH; i++) begin
        state_q[i]   <= WAIT_RISE;
        per_cnt_q[i] <= CNT_ZERO;
        hi_cnt_q[i]  <= CNT_ZERO;
        period_q[i]  <= CNT_ZERO;
        high_q[i]    <= CNT_ZERO;
      end
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      prev_q     <= prev_d;
      valid_q    <= valid_d;
      stuck_q    <= stuck_d;
      new_meas_q <= new_meas_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i]   <= state_d[i];
        per_cnt_q[i] <= per_cnt_d[i];
        hi_cnt_q[i]  <= hi_cnt_d[i];
        period_q[i]  <= period_d[i];
        high_q[i]    <= high_d[i];
      end
    end
  end

  // Next-state logic; a rise always wins over the timeout.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        WAIT_RISE: begin
          if (rise[i]) state_d[i] = MEAS;
          else         state_d[i] = WAIT_RISE;
        end
        MEAS: begin
          if (rise[i])                        state_d[i] = MEAS;
          else if (per_cnt_q[i] == CNT_MAX)   state_d[i] = WAIT_RISE;
          else                                state_d[i] = MEAS;
        end
        default: state_d[i] = WAIT_RISE;
      endcase
    end
  end

  // Counter, result and flag updates driven by the per-channel state.
  always_comb begin
    valid_d    = valid_q;
    stuck_d    = stuck_q;
    new_meas_d = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      per_cnt_d[i] = per_cnt_q[i];
      hi_cnt_d[i]  = hi_cnt_q[i];
      period_d[i]  = period_q[i];
      high_d[i]    = high_q[i];
      case (state_q[i])
        WAIT_RISE: begin
          if (rise[i]) begin
            per_cnt_d[i] = CNT_ONE;
            hi_cnt_d[i]  = CNT_ONE;
          end else begin
            per_cnt_d[i] = per_cnt_q[i];
          end
        end
        MEAS: begin
          if (rise[i]) begin
            period_d[i]   = per_cnt_q[i];
            high_d[i]     = hi_cnt_q[i];
            valid_d[i]    = 1'b1;
            stuck_d[i]    = 1'b0;
            new_meas_d[i] = 1'b1;
            per_cnt_d[i]  = CNT_ONE;
            hi_cnt_d[i]   = CNT_ONE;
          end else if (per_cnt_q[i] == CNT_MAX) begin
            stuck_d[i] = 1'b1;
            valid_d[i] = 1'b0;
          end else begin
            per_cnt_d[i] = per_cnt_q[i] + CNT_ONE;
            hi_cnt_d[i]  = hi_cnt_q[i] + {{(CW-1){1'b0}}, lvl_q[i]};
          end
        end
        default: begin
          per_cnt_d[i] = CNT_ZERO;
          hi_cnt_d[i]  = CNT_ZERO;
        end
      endcase
    end
  end

  // Read mux; selects with no matching channel leave every output at zero.
  always_comb begin
    rd_period = CNT_ZERO;
    rd_high   = CNT_ZERO;
    rd_valid  = 1'b0;
    rd_stuck  = 1'b0;
    sel_hit   = 1'b0;
    for (int i = 0; i < CH; i++) begin
      sel_hit   = (rd_sel == SELW'(i));
      rd_period = rd_period | (period_q[i] & {CW{sel_hit}});
      rd_high   = rd_high   | (high_q[i]   & {CW{sel_hit}});
      rd_valid  = rd_valid  | (valid_q[i]  & sel_hit);
      rd_stuck  = rd_stuck  | (stuck_q[i]  & sel_hit);
    end
  end

  assign new_meas = new_meas_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected measurements, a monitor
// pops and compares them on every new_meas pulse; directed checks cover the rest.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pwm_in;
  logic [2:0]  rd_sel;
  logic [15:0] rd_period, rd_high;
  logic        rd_valid, rd_stuck;
  logic [7:0]  new_meas;

  logic [3:0]  pwm_s;
  logic [2:0]  rd_sel_s;
  logic [5:0]  per_s, high_s;
  logic        valid_s, stuck_s;
  logic [3:0]  new_meas_s;

  pwm_capture #(.CH(8), .CW(16), .SELW(3)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .rd_sel(rd_sel),
    .rd_period(rd_period), .rd_high(rd_high), .rd_valid(rd_valid),
    .rd_stuck(rd_stuck), .new_meas(new_meas)
  );

  pwm_capture #(.CH(4), .CW(6), .SELW(3)) dut_s (
    .clk(clk), .rst(rst), .pwm_in(pwm_s), .rd_sel(rd_sel_s),
    .rd_period(per_s), .rd_high(high_s), .rd_valid(valid_s),
    .rd_stuck(stuck_s), .new_meas(new_meas_s)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int per; int hi;} exp_t;
  exp_t exp_q[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cfg_per[8];
  int cfg_hi[8];
  int last_cyc[8];
  int cyc = 0;
  int mon_idx;
  int nm_s_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Cycle counter and clearing of pulse-spacing history while in reset.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) for (int i = 0; i < 8; i++) last_cyc[i] = -1;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int ch = 0; ch < 8; ch++) begin
      if (new_meas[ch]) begin
        mon_idx = -1;
        for (int j = 0; j < exp_q.size(); j++)
          if (mon_idx < 0 && exp_q[j].ch == ch) mon_idx = j;
        if (mon_idx < 0) begin
          chk($sformatf("unexpected_new_meas_ch%0d", ch), 1, 0);
        end else begin
          if (int'(rd_sel) == ch) begin
            chk($sformatf("sb_period_ch%0d", ch), int'(rd_period), exp_q[mon_idx].per);
            chk($sformatf("sb_high_ch%0d", ch), int'(rd_high), exp_q[mon_idx].hi);
            chk($sformatf("sb_valid_ch%0d", ch), int'(rd_valid), 1);
            if (last_cyc[ch] >= 0)
              chk($sformatf("sb_spacing_ch%0d", ch), cyc - last_cyc[ch], exp_q[mon_idx].per);
          end
          last_cyc[ch] = cyc;
          exp_q.delete(mon_idx);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (new_meas_s[2]) nm_s_cnt = nm_s_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst    = 1'b1;
    pwm_in = 8'h00;
    pwm_s  = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle-based PWM generator; each rise after the first pushes the measurement it closes.
  task automatic run_pwm(input logic [7:0] mask, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (mask[ch]) begin
          if ((c % cfg_per[ch]) == 0 && c > 0)
            exp_q.push_back('{ch, cfg_per[ch], cfg_hi[ch]});
          pwm_in[ch] = ((c % cfg_per[ch]) < cfg_hi[ch]);
        end
      end
      @(negedge clk);
    end
    pwm_in = 8'h00;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    chk({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int first;
    rst      = 1'b1;
    pwm_in   = 8'h00;
    pwm_s    = 4'h0;
    rd_sel   = 3'd0;
    rd_sel_s = 3'd2;
    @(negedge clk);
    do_reset();
    chk("reset_period", int'(rd_period), 0);
    chk("reset_high", int'(rd_high), 0);
    chk("reset_valid", int'(rd_valid), 0);
    chk("reset_stuck", int'(rd_stuck), 0);
    chk("reset_new_meas", int'(new_meas), 0);
    chk("reset_s_valid", int'(valid_s), 0);

    // 1: period 10, high 3 on channel 0
    rd_sel = 3'd0; cfg_per[0] = 10; cfg_hi[0] = 3;
    run_pwm(8'h01, 60);
    drain("t1");
    chk("t1_period", int'(rd_period), 10);
    chk("t1_high", int'(rd_high), 3);

    // 2: all channels concurrently, period 16, high k+1
    do_reset();
    for (int k = 0; k < 8; k++) begin cfg_per[k] = 16; cfg_hi[k] = k + 1; end
    rd_sel = 3'd3;
    run_pwm(8'hFF, 64);
    drain("t2");
    for (int k = 0; k < 8; k++) begin
      rd_sel = 3'(k);
      #1;
      chk($sformatf("t2_period_ch%0d", k), int'(rd_period), 16);
      chk($sformatf("t2_high_ch%0d", k), int'(rd_high), k + 1);
      chk($sformatf("t2_valid_ch%0d", k), int'(rd_valid), 1);
    end
    @(negedge clk);

    // 4: period-2 toggle on channel 5
    do_reset();
    rd_sel = 3'd5; cfg_per[5] = 2; cfg_hi[5] = 1;
    run_pwm(8'h20, 20);
    drain("t4");
    chk("t4_period", int'(rd_period), 2);
    chk("t4_high", int'(rd_high), 1);

    // 5: one-cycle reset mid-period
    do_reset();
    rd_sel = 3'd0; cfg_per[0] = 10; cfg_hi[0] = 3;
    run_pwm(8'h01, 35);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_period", int'(rd_period), 0);
    chk("t5_rst_high", int'(rd_high), 0);
    chk("t5_rst_valid", int'(rd_valid), 0);
    chk("t5_rst_stuck", int'(rd_stuck), 0);
    chk("t5_rst_new_meas", int'(new_meas), 0);
    run_pwm(8'h01, 30);
    drain("t5");
    chk("t5_period", int'(rd_period), 10);

    // 6: latency from the sampling edge to new_meas
    do_reset();
    rd_sel = 3'd1;
    pwm_in[1] = 1'b1;
    repeat (2) @(negedge clk);
    pwm_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back('{1, 4, 2});
    pwm_in[1] = 1'b1;
    first = -1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      if (new_meas[1] && first < 0) first = e;
    end
    pwm_in[1] = 1'b0;
    chk("t6_latency_edges", first, 3);
    drain("t6");

    // 3: timeout on the CW=6 instance
    do_reset();
    rd_sel_s = 3'd2;
    for (int c = 0; c < 24; c++) begin
      pwm_s[2] = ((c % 8) < 3);
      @(negedge clk);
    end
    pwm_s[2] = 1'b1;
    repeat (8) @(negedge clk);
    chk("t3_period", int'(per_s), 8);
    chk("t3_high", int'(high_s), 3);
    chk("t3_valid", int'(valid_s), 1);
    chk("t3_stuck", int'(stuck_s), 0);
    rd_sel_s = 3'd6;
    #1;
    chk("t3_sel_oob_period", int'(per_s), 0);
    chk("t3_sel_oob_valid", int'(valid_s), 0);
    rd_sel_s = 3'd2;
    repeat (58) @(negedge clk);
    chk("t3_pre_timeout_valid", int'(valid_s), 1);
    chk("t3_pre_timeout_stuck", int'(stuck_s), 0);
    @(negedge clk);
    chk("t3_timeout_stuck", int'(stuck_s), 1);
    chk("t3_timeout_valid", int'(valid_s), 0);
    chk("t3_timeout_period_kept", int'(per_s), 8);
    chk("t3_timeout_high_kept", int'(high_s), 3);
    pwm_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    nm_s_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 11) begin
        chk("t3_restart_first_rise_pulses", nm_s_cnt, 0);
        chk("t3_restart_first_rise_stuck", int'(stuck_s), 1);
        chk("t3_restart_first_rise_valid", int'(valid_s), 0);
      end
      pwm_s[2] = ((c % 8) < 3);
      @(negedge clk);
    end
    pwm_s[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_restart_pulses", nm_s_cnt, 1);
    chk("t3_restart_valid", int'(valid_s), 1);
    chk("t3_restart_stuck", int'(stuck_s), 0);
    chk("t3_restart_period", int'(per_s), 8);
    chk("t3_restart_high", int'(high_s), 3);

    drain("final");
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
